// File: rtl/doc_pkg.sv
// Shared document geometry, character codes and receiver state type for the UART loader.
package doc_pkg;

  localparam int DOC_COLS = 20;
  localparam int DOC_ROWS = 15;
  localparam int ADDR_W   = 9;

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_SP = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 deserializer: input synchronizer, 16x oversample tick, and the frame FSM.
module uart_rx_core
  import doc_pkg::*;
#(
  parameter int OVERSAMPLE_DIV = 651
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic       active
);

  localparam int TW = (OVERSAMPLE_DIV > 1) ? $clog2(OVERSAMPLE_DIV) : 1;

  logic          rx_meta, rx_sync, rx_prev;
  logic [TW-1:0] tick_cnt;
  logic          tick;

  rx_state_t  state, state_n;
  logic [3:0] phase, phase_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shift, shift_n;
  logic       valid_n, ferr_n;

  // Synchronizer flops idle high so reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign tick = (tick_cnt == TW'(OVERSAMPLE_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      bit_idx    <= bit_idx_n;
      shift      <= shift_n;
      byte_valid <= valid_n;
      frame_err  <= ferr_n;
    end
  end

  // Start is qualified at mid-bit (8 ticks); every later sample is 16 ticks apart.
  always_comb begin
    state_n   = state;
    phase_n   = phase;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_n = START;
          phase_n = '0;
        end
      end
      START: begin
        if (tick) begin
          if (phase == 4'd7) begin
            phase_n   = '0;
            bit_idx_n = '0;
            state_n   = rx_sync ? IDLE : DATA;
          end else begin
            phase_n = phase + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (phase == 4'd15) begin
            phase_n   = '0;
            shift_n   = {rx_sync, shift[7:1]};
            bit_idx_n = bit_idx + 3'd1;
            if (bit_idx == 3'd7) state_n = STOP;
          end else begin
            phase_n = phase + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (phase == 4'd15) begin
            phase_n = '0;
            if (rx_sync) begin
              valid_n = 1'b1;
              state_n = IDLE;
            end else begin
              ferr_n  = 1'b1;
              state_n = WAIT_HIGH;
            end
          end else begin
            phase_n = phase + 4'd1;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_sync) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign byte_data = shift;
  assign active    = (state != IDLE) && (state != WAIT_HIGH);

endmodule

// File: rtl/uart_rx_loader.sv
// Receives UART characters and writes them into a DOC_ROWS x DOC_COLS text document
// through a granted write port, handling CR and backspace cursor movement.
module uart_rx_loader
  import doc_pkg::*;
#(
  parameter int OVERSAMPLE_DIV = 651,
  parameter int DOC_COLS       = doc_pkg::DOC_COLS,
  parameter int DOC_ROWS       = doc_pkg::DOC_ROWS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RsRx,
  input  logic              clear,
  input  logic              grant,
  output logic [ADDR_W-1:0] a,
  output logic [7:0]        d,
  output logic              we,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

  logic              rx_valid, rx_active;
  logic [7:0]        rx_byte;
  logic [3:0]        row;
  logic [4:0]        col;
  logic              hold_full;
  logic [7:0]        hold_byte;
  logic              wr_is_bs;
  logic              clear_pend;
  logic [ADDR_W-1:0] cur, base;
  logic              wr_done;

  uart_rx_core #(.OVERSAMPLE_DIV(OVERSAMPLE_DIV)) u_core (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (RsRx),
    .byte_valid (rx_valid),
    .byte_data  (rx_byte),
    .frame_err  (frame_err),
    .active     (rx_active)
  );

  function automatic logic [ADDR_W-1:0] pos_newline(input logic [ADDR_W-1:0] p);
    logic [3:0] r;
    r = p[ADDR_W-1:5];
    if (r == 4'(DOC_ROWS - 1)) return '0;
    return {r + 4'd1, 5'd0};
  endfunction

  function automatic logic [ADDR_W-1:0] pos_advance(input logic [ADDR_W-1:0] p);
    if (p[4:0] != 5'(DOC_COLS - 1)) return {p[ADDR_W-1:5], p[4:0] + 5'd1};
    return pos_newline(p);
  endfunction

  function automatic logic [ADDR_W-1:0] pos_retreat(input logic [ADDR_W-1:0] p);
    if (p[4:0] != 5'd0)         return {p[ADDR_W-1:5], p[4:0] - 5'd1};
    if (p[ADDR_W-1:5] != 4'd0)  return {p[ADDR_W-1:5] - 4'd1, 5'(DOC_COLS - 1)};
    return '0;
  endfunction

  assign cur     = {row, col};
  assign base    = clear ? '0 : cur;
  assign wr_done = we & grant;
  assign a       = cur;
  assign busy    = rx_active | hold_full;

  // While a write is pending the address must not move, so a clear seen then is deferred
  // until completion and overrides the post-write advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row        <= '0;
      col        <= '0;
      hold_full  <= 1'b0;
      hold_byte  <= '0;
      we         <= 1'b0;
      d          <= '0;
      wr_is_bs   <= 1'b0;
      clear_pend <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= rx_valid & hold_full;
      if (rx_valid && !hold_full) begin
        hold_full <= 1'b1;
        hold_byte <= rx_byte;
      end

      if (wr_done) begin
        we         <= 1'b0;
        hold_full  <= 1'b0;
        clear_pend <= 1'b0;
        if (clear || clear_pend) {row, col} <= '0;
        else if (!wr_is_bs)      {row, col} <= pos_advance(cur);
      end else if (we) begin
        if (clear) clear_pend <= 1'b1;
      end else if (hold_full) begin
        if (is_printable(hold_byte)) begin
          we         <= 1'b1;
          d          <= hold_byte;
          wr_is_bs   <= 1'b0;
          {row, col} <= base;
        end else if (hold_byte == CH_BS) begin
          we         <= 1'b1;
          d          <= CH_SP;
          wr_is_bs   <= 1'b1;
          {row, col} <= pos_retreat(base);
        end else if (hold_byte == CH_CR) begin
          hold_full  <= 1'b0;
          {row, col} <= clear ? '0 : pos_newline(cur);
        end else begin
          hold_full  <= 1'b0;
          {row, col} <= base;
        end
      end else if (clear) begin
        {row, col} <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_loader.sv
// Scoreboard bench for uart_rx_loader: serial frames in, expected document writes out.
module tb_uart_rx_loader;

  localparam int DIV = 4;
  localparam int BIT = 16 * DIV;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       clear;
  logic       grant;
  logic [8:0] a;
  logic [7:0] d;
  logic       we;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int f0, o0;

  logic [16:0] sb[$];
  logic [16:0] mon_exp;
  logic [3:0]  m_row;
  logic [4:0]  m_col;

  uart_rx_loader #(.OVERSAMPLE_DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .RsRx      (rx),
    .clear     (clear),
    .grant     (grant),
    .a         (a),
    .d         (d),
    .we        (we),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic modelAdvance();
    if (m_col == 5'd19) begin
      m_col = 5'd0;
      m_row = (m_row == 4'd14) ? 4'd0 : m_row + 4'd1;
    end else begin
      m_col = m_col + 5'd1;
    end
  endtask

  // Reference document behaviour for one accepted byte.
  task automatic modelByte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      sb.push_back({m_row, m_col, b});
      modelAdvance();
    end else if (b == 8'h0D) begin
      m_col = 5'd0;
      m_row = (m_row == 4'd14) ? 4'd0 : m_row + 4'd1;
    end else if (b == 8'h08) begin
      if (m_col != 5'd0) m_col = m_col - 5'd1;
      else if (m_row != 4'd0) begin
        m_row = m_row - 4'd1;
        m_col = 5'd19;
      end
      sb.push_back({m_row, m_col, 8'h20});
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit stop_ok, input bit rst_mid, input bit accept);
    logic [9:0] frame;
    frame = {stop_ok, b, 1'b0};
    if (accept) modelByte(b);
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      for (int c = 0; c < BIT; c++) begin
        if (rst_mid && i == 4 && c == BIT / 2) rst = 1'b1;
        tick();
      end
    end
    rx = 1'b1;
    for (int c = 0; c < BIT; c++) begin
      if (rst_mid && c == BIT / 2) rst = 1'b0;
      tick();
    end
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    m_row = 4'd0;
    m_col = 5'd0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 3000 && sb.size() != 0; i++) tick();
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic waitWe();
    for (int i = 0; i < 3000 && !we; i++) tick();
    checkOutput("we_pending", 32'(we), 32'd1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) ferr_cnt++;
      if (overrun)   ovr_cnt++;
      if (we && grant) begin
        checkOutput("write_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_exp = sb.pop_front();
          checkOutput("wr_addr", 32'(a), 32'(mon_exp[16:8]));
          checkOutput("wr_data", 32'(d), 32'(mon_exp[7:0]));
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rx = 1'b1; clear = 1'b0; grant = 1'b1; rst = 1'b1;
    m_row = 4'd0; m_col = 5'd0;
    repeat (5) tick();
    checkOutput("rst_a", 32'(a), 32'd0);
    checkOutput("rst_d", 32'(d), 32'd0);
    checkOutput("rst_we", 32'(we), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ferr", 32'(frame_err), 32'd0);
    checkOutput("rst_ovr", 32'(overrun), 32'd0);
    rst = 1'b0;
    repeat (BIT) tick();

    $display("[TB] single printable character");
    applyStimulus(8'h41, 1, 0, 1);
    waitDrain();
    checkOutput("cursor_after_A", 32'(a), 32'h001);
    pulseClear();
    checkOutput("cursor_cleared", 32'(a), 32'h000);

    $display("[TB] row wrap after 20 columns");
    for (int i = 0; i < 20; i++) applyStimulus(8'h42, 1, 0, 1);
    applyStimulus(8'h43, 1, 0, 1);
    waitDrain();
    checkOutput("cursor_after_C", 32'(a), 32'h021);
    pulseClear();

    $display("[TB] CR then backspace");
    applyStimulus(8'h41, 1, 0, 1);
    applyStimulus(8'h0D, 1, 0, 1);
    checkOutput("cursor_after_CR", 32'(a), 32'h020);
    applyStimulus(8'h08, 1, 0, 1);
    waitDrain();
    checkOutput("cursor_after_BS", 32'(a), 32'h013);
    pulseClear();

    $display("[TB] bad stop bit");
    f0 = ferr_cnt; o0 = ovr_cnt;
    applyStimulus(8'h61, 0, 0, 0);
    checkOutput("frame_err_pulses", 32'(ferr_cnt), 32'(f0 + 1));
    applyStimulus(8'h5A, 1, 0, 1);
    waitDrain();
    checkOutput("no_overrun_ferr", 32'(ovr_cnt), 32'(o0));

    $display("[TB] overrun with grant held low");
    grant = 1'b0;
    o0 = ovr_cnt;
    applyStimulus(8'h31, 1, 0, 1);
    applyStimulus(8'h32, 1, 0, 0);
    checkOutput("overrun_pulses", 32'(ovr_cnt), 32'(o0 + 1));
    checkOutput("held_we", 32'(we), 32'd1);
    checkOutput("held_d", 32'(d), 32'h31);
    checkOutput("held_a", 32'(a), 32'h001);
    checkOutput("held_busy", 32'(busy), 32'd1);
    grant = 1'b1;
    waitDrain();
    repeat (4) tick();
    checkOutput("busy_after_grant", 32'(busy), 32'd0);
    checkOutput("cursor_after_grant", 32'(a), 32'h002);

    $display("[TB] reset mid-frame");
    f0 = ferr_cnt; o0 = ovr_cnt;
    m_row = 4'd0; m_col = 5'd0;
    applyStimulus(8'h55, 1, 1, 0);
    checkOutput("rst_mid_a", 32'(a), 32'h000);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    checkOutput("rst_mid_ferr", 32'(ferr_cnt), 32'(f0));
    checkOutput("rst_mid_ovr", 32'(ovr_cnt), 32'(o0));
    applyStimulus(8'h55, 1, 0, 1);
    waitDrain();

    $display("[TB] clear during pending write");
    grant = 1'b0;
    applyStimulus(8'h44, 1, 0, 1);
    waitWe();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    checkOutput("clear_pend_a", 32'(a), 32'h001);
    checkOutput("clear_pend_we", 32'(we), 32'd1);
    grant = 1'b1;
    waitDrain();
    tick();
    checkOutput("clear_after_write_a", 32'(a), 32'h000);
    m_row = 4'd0; m_col = 5'd0;

    $display("[TB] start-bit glitch");
    f0 = ferr_cnt;
    rx = 1'b0;
    repeat (12) tick();
    rx = 1'b1;
    repeat (3 * BIT) tick();
    checkOutput("glitch_ferr", 32'(ferr_cnt), 32'(f0));
    checkOutput("glitch_busy", 32'(busy), 32'd0);
    checkOutput("glitch_sb", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
